inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Converts decoded instruction descriptors (op, rd, rs1, rs2, imm) into RV32I machine words and writes them sequentially into instruction memory.
- Performs the inverse of the control/immediate decoder: handles the same instruction subset (lw, sw, addi, slli, add, beq, bne, blt) and the same immediate layouts.
- Used by the testbench/boot path to load programs into imem without hand-assembled hex.

Parameters:
IMEM_WORDS, 64, instruction memory capacity in 32-bit words
ADDR_W, 8, width of imem_addr (byte address)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous: reset write pointer and error state
req_valid  in  1  descriptor valid
req_ready  out  1  block can accept descriptor
op  in  3  0=LW 1=SW 2=ADDI 3=SLLI 4=ADD 5=BEQ 6=BNE 7=BLT
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  32  signed immediate (byte offset for branches)
imem_we  out  1  one-cycle write strobe
imem_addr  out  ADDR_W  byte address, word aligned
imem_wdata  out  32  encoded instruction
count  out  ADDR_W  words written since reset/clear
full  out  1  count == IMEM_WORDS
err  out  1  sticky encode error
err_code  out  2  0 none, 1 imm out of range, 2 branch imm odd

Behaviour:
- Reset (rst_n=0, async): state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err=0, err_code=0. req_ready is combinational.
- FSM states: IDLE, ENC, WR, ERR.
- IDLE: req_ready = !full. On req_valid&&req_ready, latch all fields and go to ENC.
- ENC (1 cycle): encode and range-check.
  - On pass: register imem_wdata, set imem_addr = count*4, go to WR.
  - On fail: set err=1 and err_code, go to ERR.
- WR: imem_we=1 for exactly this cycle; count increments at its end; full recomputed; return to IDLE.
- Latency: acceptance edge N; imem_we is high during the cycle after edge N+1. Maximum throughput is one word per 3 cycles.
- ERR: req_ready=0; hold until clear. Nothing is written and count is unchanged.
- req_ready=0 in ENC, WR and ERR.
- Encodings:
  - LW: imm[11:0],rs1,010,rd,0000011
  - SW: imm[11:5],rs2,rs1,010,imm[4:0],0100011
  - ADDI: imm[11:0],rs1,000,rd,0010011
  - SLLI: 0000000,imm[4:0],rs1,001,rd,0010011
  - ADD: 0000000,rs2,rs1,000,rd,0110011
  - BEQ/BNE/BLT: imm[12],imm[10:5],rs2,rs1,f3(000/001/100),imm[4:1],imm[11],1100011
- Unused fields are ignored: rs2 for LW/ADDI/SLLI; rd for SW and branches.
- Range checks:
  - LW/SW/ADDI: -2048..2047.
  - SLLI: 0..31.
  - Branches: -4096..4094, and imm[0] must be 0 (else err_code=2; the odd check takes priority over the range check).
  - ADD: imm ignored.
- full: asserted when count==IMEM_WORDS. Requests stall (req_ready=0) while full. count never wraps. Only clear or reset releases full.
- clear: has priority over all states at the next edge.
  - Forces IDLE, count=0, err=0, err_code=0, imem_addr=0.
  - If clear is asserted while in WR, the strobe in that cycle still completes; count becomes 0, not incremented.
  - clear together with req_valid in IDLE: the request is not accepted.
- Async reset mid-ENC/WR: the transaction is dropped and imem_we falls immediately.
- imem_wdata holds its last value outside WR.

Test Plan:
- ADDI x1,x0,5 then LW x2,8(x1) -> writes 0x00500093 @0x00 and 0x0080A103 @0x04; each imem_we is a single cycle, two cycles after acceptance.
- SW x2,12(x1), ADD x3,x1,x2, BEQ x1,x2,-8 -> 0x0020A623, 0x002081B3, 0xFE208CE3 at consecutive addresses; count=3.
- BNE imm=3 -> err=1, err_code=2, no imem_we, req_ready=0; SLLI shamt 33 after clear -> err_code=1.
- IMEM_WORDS=4: five back-to-back requests with req_valid held -> 4 writes (addrs 0,4,8,12), full=1, 5th stalls; clear -> accepted at addr 0.
- Assert clear during WR -> strobe completes, count=0; drop rst_n during ENC -> no write, all outputs 0 asynchronously.
- BLT imm=4094 and imm=-4096 accepted; imm=4096 -> err_code=1.

Source files
------------

// File: rtl/inst_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// inst_encoder_loader_if
//   Request/write bundle for the instruction encoder/loader.
//   Request side : req_valid, req_ready, op, rd, rs1, rs2, imm
//   Memory side  : imem_we, imem_addr (byte address), imem_wdata
//   master : the party issuing descriptors and observing memory writes
//   slave  : the encoder/loader itself
// ---------------------------------------------------------------------------
interface inst_encoder_loader_if #(
   parameter int ADDR_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        op;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [31:0]       imm;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output req_valid, op, rd, rs1, rs2, imm,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  req_valid, op, rd, rs1, rs2, imm,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/inst_encoder_loader.sv
// ---------------------------------------------------------------------------
// inst_encoder_loader
//   Turns decoded instruction descriptors (lw, sw, addi, slli, add, beq,
//   bne, blt) into RV32I machine words and writes them to consecutive
//   word addresses of instruction memory.
//
//   Ports
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     clear      : synchronous restart: write pointer and error state
//     bus        : descriptor handshake in, imem write strobe/address/data out
//     count      : words written since reset/clear
//     full       : count has reached IMEM_WORDS; requests stall
//     err        : sticky encode error
//     err_code   : 0 none, 1 immediate out of range, 2 odd branch offset
//
//   One descriptor takes three cycles: accept (IDLE), encode (ENC),
//   write strobe (WR). An encode error parks the block in ERR until clear.
// ---------------------------------------------------------------------------
module inst_encoder_loader #(
   parameter int IMEM_WORDS = 64,
   parameter int ADDR_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   inst_encoder_loader_if.slave  bus,
   output logic [ADDR_W-1:0]     count,
   output logic                  full,
   output logic                  err,
   output logic [1:0]            err_code
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENC,
      S_WR,
      S_ERR
   } state_e;

   typedef enum logic [2:0] {
      OP_LW   = 3'd0,
      OP_SW   = 3'd1,
      OP_ADDI = 3'd2,
      OP_SLLI = 3'd3,
      OP_ADD  = 3'd4,
      OP_BEQ  = 3'd5,
      OP_BNE  = 3'd6,
      OP_BLT  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      E_NONE  = 2'd0,
      E_RANGE = 2'd1,
      E_ODD   = 2'd2
   } err_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   state_e      state;
   state_e      state_nxt;
   logic        accept;

   // Latched descriptor
   op_e         op_q;
   logic [4:0]  rd_q;
   logic [4:0]  rs1_q;
   logic [4:0]  rs2_q;
   logic [31:0] imm_q;

   // Encoder result, valid while in ENC
   logic [31:0] enc_word;
   err_e        enc_code;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values regardless of process ordering; blocking (=) is for
   // combinational logic only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic; clear overrides every state
   // ------------------------------------------------------------------------
   // NOTE: every signal assigned in an always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: if (accept)             state_nxt = S_ENC;
            S_ENC:  state_nxt = (enc_code == E_NONE) ? S_WR : S_ERR;
            S_WR:   state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs decoded from state. Ready is withheld during clear so a request
   // presented alongside clear is visibly not taken.
   // ------------------------------------------------------------------------
   always_comb begin
      full          = (count == ADDR_W'(IMEM_WORDS));
      bus.req_ready = (state == S_IDLE) && !full && !clear;
      bus.imem_we   = (state == S_WR);
      accept        = bus.req_valid && bus.req_ready;
   end

   // ------------------------------------------------------------------------
   // Descriptor capture
   // ------------------------------------------------------------------------
   // NOTE: payload registers carry no reset: they are only consumed in ENC,
   // which is always preceded by an accept that loads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q  <= op_e'(bus.op);
         rd_q  <= bus.rd;
         rs1_q <= bus.rs1;
         rs2_q <= bus.rs2;
         imm_q <= bus.imm;
      end
   end

   // ------------------------------------------------------------------------
   // Encoder and immediate range check
   // ------------------------------------------------------------------------
   logic signed [31:0] imm_s;
   logic               i_range_bad;
   logic               b_range_bad;
   logic [2:0]         br_f3;

   always_comb begin
      imm_s       = $signed(imm_q);
      i_range_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      b_range_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
      enc_word    = '0;
      enc_code    = E_NONE;
      br_f3       = 3'b000;

      unique case (op_q)
         OP_LW: begin
            enc_word = {imm_q[11:0], rs1_q, 3'b010, rd_q, OPC_LOAD};
            if (i_range_bad) enc_code = E_RANGE;
         end
         OP_SW: begin
            enc_word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], OPC_STORE};
            if (i_range_bad) enc_code = E_RANGE;
         end
         OP_ADDI: begin
            enc_word = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_OPIMM};
            if (i_range_bad) enc_code = E_RANGE;
         end
         OP_SLLI: begin
            enc_word = {7'b0000000, imm_q[4:0], rs1_q, 3'b001, rd_q, OPC_OPIMM};
            // Unsigned compare: negative shift amounts are also rejected.
            if (imm_q > 32'd31) enc_code = E_RANGE;
         end
         OP_ADD: begin
            enc_word = {7'b0000000, rs2_q, rs1_q, 3'b000, rd_q, OPC_OP};
         end
         default: begin
            // Branches share the B-type layout; only funct3 differs.
            if (op_q == OP_BNE)      br_f3 = 3'b001;
            else if (op_q == OP_BLT) br_f3 = 3'b100;
            enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, br_f3,
                        imm_q[4:1], imm_q[11], OPC_BRANCH};
            // An odd offset is reported ahead of an out-of-range one.
            if (imm_q[0])         enc_code = E_ODD;
            else if (b_range_bad) enc_code = E_RANGE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Write pointer, write data and error state
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         count          <= '0;
         err            <= 1'b0;
         err_code       <= 2'd0;
      end else if (clear) begin
         // imem_wdata keeps its last value; a strobe in progress still
         // completes with it, but the pointer restarts from zero.
         bus.imem_addr <= '0;
         count         <= '0;
         err           <= 1'b0;
         err_code      <= 2'd0;
      end else begin
         unique case (state)
            S_ENC: begin
               if (enc_code == E_NONE) begin
                  bus.imem_wdata <= enc_word;
                  bus.imem_addr  <= {count[ADDR_W-3:0], 2'b00};
               end else begin
                  err      <= 1'b1;
                  err_code <= enc_code;
               end
            end
            S_WR: begin
               count <= count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder_loader
//   Drives descriptors into inst_encoder_loader, predicts each memory write
//   with an arithmetic RV32I encoder model and checks writes from a separate
//   monitor process against a queue of expected writes.
// ---------------------------------------------------------------------------
module tb_inst_encoder_loader;

   localparam int IMEM_WORDS = 8;
   localparam int ADDR_W     = 8;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic              clear = 1'b0;
   logic [ADDR_W-1:0] count;
   logic              full;
   logic              err;
   logic [1:0]        err_code;

   inst_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

   inst_encoder_loader #(
      .IMEM_WORDS (IMEM_WORDS),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .bus      (bus),
      .count    (count),
      .full     (full),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int                cyc;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   int  mcount   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference encoder: plain field arithmetic over the instruction formats.
   function automatic void ref_encode(input int o, input int rd_i, input int rs1_i,
                                      input int rs2_i, input int imm_i,
                                      output logic [31:0] w, output int code);
      logic [31:0] u;
      int f3;
      u    = imm_i;
      w    = 0;
      code = 0;
      case (o)
         0: begin
            w = ((u & 32'hfff) << 20) | (rs1_i << 15) | (2 << 12) | (rd_i << 7) | 32'h03;
            if (imm_i < -2048 || imm_i > 2047) code = 1;
         end
         1: begin
            w = (((u >> 5) & 32'h7f) << 25) | (rs2_i << 20) | (rs1_i << 15) | (2 << 12)
              | ((u & 32'h1f) << 7) | 32'h23;
            if (imm_i < -2048 || imm_i > 2047) code = 1;
         end
         2: begin
            w = ((u & 32'hfff) << 20) | (rs1_i << 15) | (rd_i << 7) | 32'h13;
            if (imm_i < -2048 || imm_i > 2047) code = 1;
         end
         3: begin
            w = ((u & 32'h1f) << 20) | (rs1_i << 15) | (1 << 12) | (rd_i << 7) | 32'h13;
            if (imm_i < 0 || imm_i > 31) code = 1;
         end
         4: begin
            w = (rs2_i << 20) | (rs1_i << 15) | (rd_i << 7) | 32'h33;
         end
         default: begin
            f3 = (o == 5) ? 0 : (o == 6) ? 1 : 4;
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2_i << 20)
              | (rs1_i << 15) | (f3 << 12) | (((u >> 1) & 32'hf) << 8)
              | (((u >> 11) & 1) << 7) | 32'h63;
            if (imm_i % 2 != 0) code = 2;
            else if (imm_i < -4096 || imm_i > 4094) code = 1;
         end
      endcase
   endfunction

   // Monitor: every strobe must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected write strobe", bus.imem_we, 0);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("write addr", bus.imem_addr, e.addr);
               check("write data", bus.imem_wdata, e.data);
               check("write cycle", cyc, e.cyc);
            end
         end
      end
   end

   // Issue one descriptor; returns the model's error code, -1 if never accepted.
   task automatic send(input int o, input int rd_i, input int rs1_i, input int rs2_i,
                       input int imm_i, input logic [31:0] golden, input bit use_golden,
                       output int code);
      logic [31:0] w;
      bit ok;
      bus.op        = o[2:0];
      bus.rd        = rd_i[4:0];
      bus.rs1       = rs1_i[4:0];
      bus.rs2       = rs2_i[4:0];
      bus.imm       = imm_i;
      bus.req_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready === 1'b1) ok = 1;
      end
      if (!ok) begin
         check("accept timeout", bus.req_ready, 1);
         bus.req_valid = 1'b0;
         code = -1;
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      ref_encode(o, rd_i, rs1_i, rs2_i, imm_i, w, code);
      if (code == 0) begin
         exp_q.push_back('{addr: ADDR_W'(mcount * 4), data: (use_golden ? golden : w), cyc: cyc + 1});
         mcount++;
      end
   endtask

   task automatic wait_idle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      mcount = 0;
   endtask

   task automatic expect_error(input int code);
      repeat (3) @(negedge clk);
      check("err sticky", err, 1);
      check("err_code", err_code, code);
      check("ready in ERR", bus.req_ready, 0);
      check("count after err", count, mcount);
   endtask

   initial begin
      int code;
      bus.req_valid = 1'b0;
      bus.op  = '0;
      bus.rd  = '0;
      bus.rs1 = '0;
      bus.rs2 = '0;
      bus.imm = '0;

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      check("rst imem_we", bus.imem_we, 0);
      check("rst imem_addr", bus.imem_addr, 0);
      check("rst imem_wdata", bus.imem_wdata, 0);
      check("rst count", count, 0);
      check("rst full", full, 0);
      check("rst err", err, 0);
      check("rst err_code", err_code, 0);
      check("rst req_ready", bus.req_ready, 1);
      #9 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ADDI x1,x0,5 ; LW x2,8(x1)
      send(2, 1, 0, 0, 5, 32'h00500093, 1, code);
      send(0, 2, 1, 0, 8, 32'h0080A103, 1, code);
      wait_idle();
      check("count after 2", count, 2);

      // SW x2,12(x1) ; ADD x3,x1,x2 ; BEQ x1,x2,-8
      do_clear();
      send(1, 0, 1, 2, 12, 32'h0020A623, 1, code);
      send(4, 3, 1, 2, 0, 32'h002081B3, 1, code);
      send(5, 0, 1, 2, -8, 32'hFE208CE3, 1, code);
      wait_idle();
      check("count after 3", count, 3);
      check("full after 3", full, 0);

      // Odd branch offset, then out-of-range shift amount
      send(6, 0, 1, 2, 3, 32'h0, 0, code);
      expect_error(2);
      do_clear();
      check("err cleared", err, 0);
      check("err_code cleared", err_code, 0);
      send(3, 1, 1, 0, 33, 32'h0, 0, code);
      expect_error(1);
      do_clear();

      // Branch range edges
      send(7, 0, 3, 4, 4094, 32'h0, 0, code);
      send(7, 0, 3, 4, -4096, 32'h0, 0, code);
      send(7, 0, 3, 4, 4096, 32'h0, 0, code);
      expect_error(1);
      do_clear();

      // Fill memory, stall while full, clear releases
      for (int i = 0; i < IMEM_WORDS; i++) send(4, i + 1, i, i + 2, 0, 32'h0, 0, code);
      wait_idle();
      check("full asserted", full, 1);
      check("count at capacity", count, IMEM_WORDS);
      bus.op = 3'd4;
      bus.req_valid = 1'b1;
      repeat (10) @(negedge clk);
      check("stall while full", bus.req_ready, 0);
      @(posedge clk);
      #1 clear = 1'b1;
      mcount = 0;
      @(negedge clk);
      check("no accept during clear", bus.req_ready, 0);
      @(posedge clk);
      #1 clear = 1'b0;
      check("count cleared", count, 0);
      check("full released", full, 0);
      send(4, 5, 6, 7, 0, 32'h0, 0, code);

      // Clear during WR: strobe completes, pointer restarts at zero
      send(2, 9, 10, 0, -1, 32'h0, 0, code);
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      mcount = 0;
      check("count after clear in WR", count, 0);

      // Reset during ENC: transaction dropped, outputs fall immediately
      send(2, 1, 2, 0, 100, 32'h0, 0, code);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      mcount = 0;
      #1;
      check("async rst imem_we", bus.imem_we, 0);
      check("async rst imem_addr", bus.imem_addr, 0);
      check("async rst imem_wdata", bus.imem_wdata, 0);
      check("async rst count", count, 0);
      check("async rst err", err, 0);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized descriptors
      for (int n = 0; n < 80; n++) begin
         int o, imm_v, sel;
         if (mcount == IMEM_WORDS) begin
            wait_idle();
            check("random full", full, 1);
            do_clear();
         end
         o   = $urandom_range(0, 7);
         sel = $urandom_range(0, 9);
         if (sel >= 8) imm_v = int'($urandom_range(0, 16383)) - 8192;
         else if (o == 3) imm_v = $urandom_range(0, 31);
         else if (o >= 5) imm_v = int'($urandom_range(0, 4095)) * 2 - 4096;
         else imm_v = int'($urandom_range(0, 4095)) - 2048;
         send(o, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              imm_v, 32'h0, 0, code);
         if (code > 0) begin
            expect_error(code);
            do_clear();
         end
      end

      wait_idle();
      check("pending writes", exp_q.size(), 0);
      check("final count", count, mcount);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
